// File: rtl/ysyx_23060278_ifu.sv
// Instruction fetch unit: one outstanding memory read, a single-entry instruction
// holding register toward the decoder, and redirect handling that squashes in-flight fetches.
module ysyx_23060278_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,

    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,

    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] redirect_tgt;

    // Instructions are word aligned; the low two target bits carry no meaning here.
    assign redirect_tgt  = redirect_pc & 32'hFFFF_FFFC;

    assign mem_req_valid = (state_q == S_REQ);
    assign mem_req_addr  = pc_q;
    assign inst_valid    = (state_q == S_HOLD);
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;
    assign fetch_cnt     = fetch_cnt_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        fetch_cnt_d = fetch_cnt_q;

        case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
                if (mem_req_ready) begin
                    // A redirect racing the accept makes the in-flight word stale.
                    state_d = S_WAIT;
                    drop_d  = redirect_valid;
                end
            end

            S_WAIT: begin
                if (mem_resp_valid) begin
                    if (drop_q || redirect_valid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                        if (redirect_valid) begin
                            pc_d = redirect_tgt;
                        end
                    end else begin
                        inst_d    = mem_resp_data;
                        inst_pc_d = pc_q;
                        state_d   = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_d   = redirect_tgt;
                    drop_d = 1'b1;
                end
            end

            S_HOLD: begin
                // A redirect wins over the consume handshake: the held word is wrong-path.
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    pc_d        = pc_q + 32'd4;
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                    state_d     = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            inst_q      <= 32'd0;
            inst_pc_q   <= 32'd0;
            fetch_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

endmodule
